lock_chamber: RTL and testbench

Chamber-level and exit-gate controller for the two-gate canal lock. Sits directly downstream of the entry-gate controller.
- Consumes its `occupied` flag.
- Raises the chamber level and opens the exit gate.
- Drains back to the entry level.
- Returns `water_level` and `exited` to the entry-gate controller to close the loop.

---
 rtl/lock_pkg.sv | 16 +
 rtl/level_stepper.sv | 52 +++++
 rtl/lock_chamber.sv | 92 +++++++++
 tb/tb_lock_chamber.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared types and default sizing for the canal lock controllers.
// The entry-gate bench reuses these defaults.
package lock_pkg;

  typedef enum logic [2:0] {
    LOW,
    FILL,
    HIGH,
    OPEN,
    DRAIN
  } lock_state_t;

  localparam int LEVEL_MAX_DEF   = 15;
  localparam int STEP_CYCLES_DEF = 4;

endpackage

// File: rtl/level_stepper.sv
// Prescaled, saturating up/down chamber level counter.
// at_max/at_min strobe on the step that lands on a bound.
import lock_pkg::*;

module level_stepper #(
  parameter int LEVEL_MAX   = LEVEL_MAX_DEF,
  parameter int STEP_CYCLES = STEP_CYCLES_DEF,
  localparam int LW = $clog2(LEVEL_MAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          up,
  input  logic          down,
  input  logic          freeze,
  output logic [LW-1:0] level,
  output logic          at_max,
  output logic          at_min
);

  localparam int PW =
    (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [PW-1:0] PLAST =
    PW'(STEP_CYCLES - 1);
  localparam logic [LW-1:0] LMAX = LW'(LEVEL_MAX);
  localparam logic [LW-1:0] LONE = LW'(1);

  logic [PW-1:0] psc;
  logic          step;
  logic          top;
  logic          bot;

  assign step   = (up | down) & ~freeze & (psc == PLAST);
  assign top    = (level == LMAX);
  assign bot    = (level == '0);
  assign at_max = step & up & (level == LMAX - LONE);
  assign at_min = step & down & ~up & (level == LONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      psc   <= '0;
      level <= '0;
    end else if (!freeze) begin
      if (!(up | down) || step) psc <= '0;
      else psc <= psc + 1'b1;
      if (step & up & ~top)
        level <= level + LONE;
      else if (step & down & ~up & ~bot)
        level <= level - LONE;
    end
  end

endmodule

// File: rtl/lock_chamber.sv
// Chamber level and exit-gate controller for the canal lock.
// LOCK_ESTOP_EN adds an estop input that freezes all motion.
import lock_pkg::*;

module lock_chamber #(
  parameter int LEVEL_MAX   = LEVEL_MAX_DEF,
  parameter int STEP_CYCLES = STEP_CYCLES_DEF,
  localparam int LW = $clog2(LEVEL_MAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
`ifdef LOCK_ESTOP_EN
  input  logic          estop,
`endif
  input  logic          occupied,
  input  logic          gate2_sw,
  output logic [LW-1:0] level,
  output logic          water_level,
  output logic          gate2_li,
  output logic          gate2_open,
  output logic          exited,
  output logic          filling,
  output logic          draining
);

  lock_state_t state;
  lock_state_t nxt;
  logic        frz;
  logic        at_max;
  logic        at_min;
  logic        li_q;
  logic        open_q;

`ifdef LOCK_ESTOP_EN
  assign frz = estop;
`else
  assign frz = 1'b0;
`endif

  level_stepper #(
    .LEVEL_MAX   (LEVEL_MAX),
    .STEP_CYCLES (STEP_CYCLES)
  ) u_step (
    .clk    (clk),
    .reset  (reset),
    .up     (state == FILL),
    .down   (state == DRAIN),
    .freeze (frz),
    .level  (level),
    .at_max (at_max),
    .at_min (at_min)
  );

  always_comb begin
    nxt = state;
    if (!frz) begin
      unique case (state)
        LOW:     if (occupied)  nxt = FILL;
        FILL:    if (at_max)    nxt = HIGH;
        HIGH:    if (gate2_sw)  nxt = OPEN;
        OPEN:    if (!gate2_sw) nxt = DRAIN;
        DRAIN:   if (at_min)    nxt = LOW;
        default:                nxt = LOW;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= LOW;
      water_level <= 1'b1;
      li_q        <= 1'b0;
      open_q      <= 1'b0;
      exited      <= 1'b0;
      filling     <= 1'b0;
      draining    <= 1'b0;
    end else begin
      state       <= nxt;
      water_level <= (nxt == LOW);
      li_q        <= (nxt == HIGH);
      open_q      <= (nxt == OPEN);
      filling     <= (nxt == FILL);
      draining    <= (nxt == DRAIN);
      exited      <= (state == OPEN) && (nxt == DRAIN);
    end
  end

  // Gate permissions drop the moment estop rises.
  assign gate2_li   = li_q & ~frz;
  assign gate2_open = open_q & ~frz;

endmodule

// File: tb/tb_lock_chamber.sv
// Scoreboard bench for lock_chamber, LEVEL_MAX=3, STEP_CYCLES=2.
module tb_lock_chamber;

  localparam logic [5:0] W  = 6'b100000;
  localparam logic [5:0] LI = 6'b010000;
  localparam logic [5:0] OP = 6'b001000;
  localparam logic [5:0] EX = 6'b000100;
  localparam logic [5:0] FI = 6'b000010;
  localparam logic [5:0] DR = 6'b000001;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       occupied = 1'b0;
  logic       gate2_sw = 1'b0;
  logic       estop = 1'b0;
  logic [1:0] level;
  logic       water_level;
  logic       gate2_li;
  logic       gate2_open;
  logic       exited;
  logic       filling;
  logic       draining;

  int tests = 0;
  int fails = 0;

  string      qn[$];
  int         ql[$];
  logic [5:0] qf[$];

  always #5 clk = ~clk;

  lock_chamber #(
    .LEVEL_MAX   (3),
    .STEP_CYCLES (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
`ifdef LOCK_ESTOP_EN
    .estop       (estop),
`endif
    .occupied    (occupied),
    .gate2_sw    (gate2_sw),
    .level       (level),
    .water_level (water_level),
    .gate2_li    (gate2_li),
    .gate2_open  (gate2_open),
    .exited      (exited),
    .filling     (filling),
    .draining    (draining)
  );

  function automatic void chk(
    input string n, input int el, input logic [5:0] ef);
    logic [5:0] af;
    af = {water_level, gate2_li, gate2_open,
          exited, filling, draining};
    tests++;
    if (int'(level) != el || af !== ef) begin
      fails++;
      $display("FAIL %s: got level=%0d flags=%b, want level=%0d flags=%b",
               n, level, af, el, ef);
    end
  endfunction

  // Monitor: outputs are presented every cycle, check at negedge.
  initial begin
    forever begin
      @(negedge clk);
      if (qn.size() > 0)
        chk(qn.pop_front(), ql.pop_front(), qf.pop_front());
    end
  end

  task automatic t(input string n, input logic r, input logic o,
                   input logic s, input logic e,
                   input int el, input logic [5:0] ef);
    @(negedge clk);
    #1;
    reset = r;
    occupied = o;
    gate2_sw = s;
    estop = e;
    qn.push_back(n);
    ql.push_back(el);
    qf.push_back(ef);
  endtask

  task automatic fill_run(input logic s);
    for (int i = 1; i < 6; i++) t("fill", 1, 0, s, 0, i / 2, FI);
    t("high", 1, 0, s, 0, 3, LI);
  endtask

  task automatic drain_run(input logic o);
    for (int i = 1; i < 6; i++) t("drain", 1, o, 0, 0, 3 - i / 2, DR);
    t("low_back", 1, o, 0, 0, 0, W);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    t("rst_hold", 0, 0, 0, 0, 0, W);
    t("rst_hold", 0, 0, 0, 0, 0, W);
    for (int i = 0; i < 5; i++) t("idle", 1, 0, 0, 0, 0, W);

    // Fill, wait in HIGH, open 4 cycles, drain with occupied still set.
    t("fill_go", 1, 1, 0, 0, 0, FI);
    fill_run(1'b0);
    t("high_wait", 1, 0, 0, 0, 3, LI);
    t("high_wait", 1, 0, 0, 0, 3, LI);
    for (int i = 0; i < 4; i++) t("open", 1, 0, 1, 0, 3, OP);
    t("exit", 1, 1, 0, 0, 3, EX | DR);
    drain_run(1'b1);
    t("low_idle", 1, 0, 0, 0, 0, W);
    t("low_idle", 1, 0, 0, 0, 0, W);

    // Switch already on when HIGH is reached.
    t("fill_go2", 1, 1, 1, 0, 0, FI);
    fill_run(1'b1);
    t("open2", 1, 0, 1, 0, 3, OP);
    t("exit2", 1, 0, 0, 0, 3, EX | DR);
    drain_run(1'b0);
    t("low_idle2", 1, 0, 0, 0, 0, W);

    // Reset mid-FILL at level 2.
    t("fill_go3", 1, 1, 0, 0, 0, FI);
    for (int i = 1; i < 5; i++) t("fill3", 1, 0, 0, 0, i / 2, FI);
    t("rst_mid", 0, 0, 0, 0, 0, W);
    #1 chk("rst_async", 0, W);
    t("rst_mid_hold", 0, 0, 0, 0, 0, W);
    for (int i = 0; i < 3; i++) t("rst_rel", 1, 0, 0, 0, 0, W);

`ifdef LOCK_ESTOP_EN
    // Freeze at level 1 for 3 cycles; HIGH 9 cycles after FILL entry.
    t("es_go", 1, 1, 0, 0, 0, FI);
    t("es_fill", 1, 0, 0, 0, 0, FI);
    t("es_fill", 1, 0, 0, 0, 1, FI);
    for (int i = 0; i < 3; i++) t("es_frz", 1, 0, 0, 1, 1, FI);
    for (int i = 3; i < 6; i++) t("es_res", 1, 0, 0, 0, i / 2, FI);
    t("es_high", 1, 0, 0, 0, 3, LI);
    t("es_li_off", 1, 0, 0, 1, 3, 6'b000000);
    t("es_li_on", 1, 0, 0, 0, 3, LI);
    t("es_open", 1, 0, 1, 0, 3, OP);
    t("es_exit", 1, 0, 0, 0, 3, EX | DR);
    drain_run(1'b0);
`endif

    for (int i = 0; i < 10 && qn.size() > 0; i++) begin
      @(negedge clk);
      #2;
    end
    if (qn.size() > 0) begin
      fails++;
      $display("FAIL drain_queue: got %0d pending, want 0", qn.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
